// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width plus the memory-port arbiter
// state and owner encodings.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCESS,
    DONE
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-state counter for the memory-port arbiter. It loads WAIT_CYCLES,
// counts down while the access runs, and flags the final access cycle.
module wait_counter #(
  parameter int CNT_W       = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WAIT_CYCLES);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the fetch and load/store requesters.
// Defining ARB_ROUND_ROBIN_EN alternates the winner on contention; otherwise data has priority.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] fetch_addr,
  input  logic             data_req,
  input  logic             data_we,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] data_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             rd,
  output logic             wr,
  output logic             fetch_gnt,
  output logic             data_gnt,
  output logic             fetch_done,
  output logic             data_done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > (2**CNT_W) - 1) begin : gBadWait
      $error("mem_port_arbiter: WAIT_CYCLES out of range for CNT_W");
    end
  endgenerate

  arbState_t state;
  owner_t    owner;
  logic      isStore;
  logic      cntLast;
  logic      pickData;

`ifdef ARB_ROUND_ROBIN_EN
  // High when fetch should win the next tie, i.e. data was served last.
  logic rrFavorFetch;
  assign pickData = data_req && (!fetch_req || !rrFavorFetch);
`else
  assign pickData = data_req;
`endif

  wait_counter #(
    .CNT_W      (CNT_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) uWaitCounter (
    .clk  (clk),
    .reset(reset),
    .load (state == GRANT),
    .dec  (state == ACCESS),
    .last (cntLast)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      isStore    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      fetch_gnt  <= 1'b0;
      data_gnt   <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rrFavorFetch <= 1'b1;
`endif
    end else begin
      fetch_gnt  <= 1'b0;
      data_gnt   <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            state    <= GRANT;
            busy     <= 1'b1;
            owner    <= pickData ? OWN_DATA : OWN_FETCH;
            isStore  <= pickData && data_we;
            mem_addr <= pickData ? data_addr : fetch_addr;
            if (pickData) mem_wdata <= data_wdata;
            data_gnt  <= pickData;
            fetch_gnt <= !pickData;
          end
        end
        GRANT: begin
          state <= ACCESS;
          rd    <= !isStore;
          wr    <= isStore;
        end
        ACCESS: begin
          if (cntLast) begin
            state <= DONE;
            rd    <= 1'b0;
            wr    <= 1'b0;
            if (!isStore) rdata <= mem_rdata;
            fetch_done <= (owner == OWN_FETCH);
            data_done  <= (owner == OWN_DATA);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          owner <= OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
          rrFavorFetch <= (owner == OWN_DATA);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction-level check of mem_port_arbiter against a simple
// memory and arbitration model; honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int WC = 2;

  logic          clk;
  logic          reset;
  logic          fetch_req;
  logic [W-1:0]  fetch_addr;
  logic          data_req;
  logic          data_we;
  logic [W-1:0]  data_addr;
  logic [W-1:0]  data_wdata;
  logic [W-1:0]  mem_rdata;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          rd;
  logic          wr;
  logic          fetch_gnt;
  logic          data_gnt;
  logic          fetch_done;
  logic          data_done;
  logic [W-1:0]  rdata;
  logic          busy;

  int vectors = 0;
  int errors  = 0;
  int txnNum  = 0;

  logic [W-1:0] memArr   [0:15];
  logic [W-1:0] modelMem [0:15];
  logic [W-1:0] expRdata;
  bit           lastWasData;

  mem_port_arbiter #(.WIDTH(W), .WAIT_CYCLES(WC), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .rd        (rd),
    .wr        (wr),
    .fetch_gnt (fetch_gnt),
    .data_gnt  (data_gnt),
    .fetch_done(fetch_done),
    .data_done (data_done),
    .rdata     (rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: combinational read, write on any clock with wr high.
  assign mem_rdata = memArr[mem_addr[5:2]];
  always @(posedge clk) begin
    if (wr) memArr[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 into an IDLE cycle with requests already driven.
  task automatic runOne(input bit holdExtra);
    bit isData, isStore;
    logic [W-1:0] addr, wd;
    checkVal("idleBusy", {31'b0, busy}, 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    isData = data_req && (!fetch_req || !lastWasData);
`else
    isData = data_req;
`endif
    isStore = isData && data_we;
    addr    = isData ? data_addr : fetch_addr;
    wd      = data_wdata;
    @(posedge clk); #1;
    checkVal("gntFetch", {31'b0, fetch_gnt}, {31'b0, !isData});
    checkVal("gntData",  {31'b0, data_gnt},  {31'b0, isData});
    checkVal("gntStrobe", {30'b0, rd, wr}, 32'd0);
    checkVal("gntAddr", mem_addr, addr);
    checkVal("gntBusy", {31'b0, busy}, 32'd1);
    for (int c = 0; c < WC; c++) begin
      @(posedge clk); #1;
      checkVal("accStrobe", {30'b0, rd, wr}, {30'b0, !isStore, isStore});
      checkVal("accAddr", mem_addr, addr);
      checkVal("accPulses", {28'b0, fetch_gnt, data_gnt, fetch_done, data_done}, 32'd0);
      if (isStore) checkVal("accWdata", mem_wdata, wd);
    end
    if (!isStore) expRdata = modelMem[addr[5:2]];
    @(posedge clk); #1;
    checkVal("doneFetch", {31'b0, fetch_done}, {31'b0, !isData});
    checkVal("doneData",  {31'b0, data_done},  {31'b0, isData});
    checkVal("doneStrobe", {30'b0, rd, wr}, 32'd0);
    checkVal("doneRdata", rdata, expRdata);
    if (isStore) modelMem[addr[5:2]] = wd;
    lastWasData = isData;
    $display("txn %0d: %s %s addr=%h wdata=%h rdata=%h hold=%0d", txnNum,
             isData ? "data " : "fetch", isStore ? "st" : "ld", addr, wd, rdata, holdExtra);
    txnNum++;
    if (!holdExtra) begin
      if (isData) data_req = 1'b0;
      else        fetch_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic raiseFetch(input logic [W-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
  endtask

  task automatic raiseData(input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = a;
    data_wdata = d;
  endtask

  initial begin
    logic [W-1:0] ra;
    reset      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    expRdata   = '0;
    lastWasData = 1'b1;
    for (int i = 0; i < 16; i++) begin
      memArr[i]   = $urandom;
      modelMem[i] = memArr[i];
    end
    memArr[0]   = 32'hDEADBEEF;
    modelMem[0] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    checkVal("rstOuts", {25'b0, rd, wr, fetch_gnt, data_gnt, fetch_done, data_done, busy}, 32'd0);
    checkVal("rstAddr", mem_addr, 32'd0);
    checkVal("rstWdata", mem_wdata, 32'd0);
    checkVal("rstRdata", rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    raiseFetch(32'h100);
    runOne(1'b0);
    raiseData(1'b1, 32'h200, 32'h12345678);
    runOne(1'b0);
    raiseFetch(32'h104);
    raiseData(1'b0, 32'h208, 32'h0);
    runOne(1'b0);
    runOne(1'b0);

    // Both requesters held continuously; each re-raises straight after service.
    for (int k = 0; k < 4; k++) begin
      if (!fetch_req) raiseFetch({$urandom} & 32'hFFFF_FFFC);
      if (!data_req)  raiseData(1'b0, {$urandom} & 32'hFFFF_FFFC, $urandom);
      runOne(1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      if (!fetch_req && ($urandom_range(0, 1) == 1)) begin
        ra = $urandom;
        ra[1:0] = 2'b00;
        raiseFetch(ra);
      end
      if (!data_req && ($urandom_range(0, 1) == 1)) begin
        ra = $urandom;
        ra[1:0] = 2'b00;
        raiseData($urandom_range(0, 1) == 1, ra, $urandom);
      end
      if (!fetch_req && !data_req) raiseFetch(32'h40);
      runOne($urandom_range(0, 4) == 0);
    end

    // Reset during the ACCESS phase of a load.
    fetch_req = 1'b0;
    data_req  = 1'b0;
    raiseData(1'b0, 32'h40, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    checkVal("preRstRd", {31'b0, rd}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkVal("midRstOuts", {25'b0, rd, wr, fetch_gnt, data_gnt, fetch_done, data_done, busy}, 32'd0);
    checkVal("midRstAddr", mem_addr, 32'd0);
    checkVal("midRstRdata", rdata, 32'd0);
    data_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checkVal("noDoneAfterRst", {30'b0, data_done, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single memory port between two requesters: the instruction-fetch path (PC/MAR/IR) and the load/store path (MDR).
- Grants one requester at a time.
- Sequences each access through address setup, wait states and completion.
- Drives the memory rd/wr strobes and returns captured read data.
- Sits between the controller's fetch/load/store micro-ops and the memory model.

Parameters:
WIDTH, 32, address/data width in bits
WAIT_CYCLES, 2, cycles rd/wr is held asserted per access; legal range 1..(2**CNT_W)-1
CNT_W, 4, width of the internal wait-state counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch requester wants a read; held until fetch_done
fetch_addr  input  WIDTH  fetch address
data_req  input  1  load/store requester wants an access; held until data_done
data_we  input  1  1 = store, 0 = load
data_addr  input  WIDTH  load/store address
data_wdata  input  WIDTH  store data
mem_rdata  input  WIDTH  memory read data
mem_addr  output  WIDTH  registered memory address
mem_wdata  output  WIDTH  registered memory write data
rd  output  1  memory read strobe
wr  output  1  memory write strobe
fetch_gnt  output  1  one-cycle pulse: fetch transaction accepted
data_gnt  output  1  one-cycle pulse: load/store transaction accepted
fetch_done  output  1  one-cycle pulse: fetch complete, rdata valid
data_done  output  1  one-cycle pulse: load/store complete, rdata valid for loads
rdata  output  WIDTH  read data captured at end of access
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (reset=0).
- On reset:
  - state=IDLE, owner=none, counter=0, rr pointer=fetch.
  - All outputs 0, including mem_addr, mem_wdata and rdata.
- States: IDLE -> GRANT -> ACCESS -> DONE -> IDLE.
- IDLE:
  - busy=0. Requests are sampled here only.
  - If any req is high at the edge: latch winner, address, we and wdata, then go to GRANT.
  - Both high: data wins (fixed priority; see Optional Feature).
- GRANT (1 cycle):
  - Winner's gnt=1; mem_addr/mem_wdata hold latched values; rd=wr=0 (address setup).
  - Load counter with WAIT_CYCLES. Go to ACCESS.
- ACCESS (exactly WAIT_CYCLES cycles):
  - rd=1 for fetch/load; wr=1 for store. mem_addr stable.
  - Counter decrements each cycle.
  - On the edge where counter reaches 1: reads capture mem_rdata into rdata; go to DONE.
- DONE (1 cycle):
  - rd=wr=0; winner's done=1; rdata holds its value. Unconditionally go to IDLE.
- Latency: req sampled at edge 0 -> gnt in cycle 1 -> rd/wr in cycles 2..1+WAIT_CYCLES -> done in cycle 2+WAIT_CYCLES. Turnaround is 3+WAIT_CYCLES cycles per transaction.
- Requester contract:
  - Hold req and operands stable until done.
  - Drop req by the edge that ends DONE; a req still high in IDLE is treated as a new transaction.
- Changes to the non-owner's req/addr while busy are ignored. A pending req is serviced at the next IDLE.
- Stores leave rdata unchanged.
- gnt and done are never asserted for both requesters in the same cycle. rd and wr are never both 1.
- Reset mid-transaction:
  - Strobes drop immediately; no done is issued; return to IDLE.
  - Requesters must re-issue.
- WAIT_CYCLES outside the legal range: elaboration-time $error.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: when both reqs are high in IDLE, the requester not served most recently wins. The rr pointer updates on each DONE; reset value favours fetch.
- Undefined: fixed data-over-fetch priority and no rr pointer. Fetch may starve under back-to-back data requests; this is accepted.

Decomposition:
- Shared package cpu_pkg holds:
  - the WIDTH default;
  - the arbiter state encoding (IDLE, GRANT, ACCESS, DONE);
  - the owner encoding (OWN_NONE, OWN_FETCH, OWN_DATA).
- One natural sub-module: wait_counter. Interface: load, decrement and last-cycle flag, with CNT_W and WAIT_CYCLES as parameters.

Test Plan:
- Reset low mid-ACCESS of a load to 0x40 -> rd=0, busy=0 and all outputs 0 within the same cycle; no data_done afterwards.
- fetch_req alone, fetch_addr=0x100, mem_rdata=0xDEADBEEF, WAIT_CYCLES=2 -> fetch_gnt in cycle 1, rd high cycles 2-3, fetch_done in cycle 4, rdata=0xDEADBEEF.
- Store: data_req=1, data_we=1, addr=0x200, wdata=0x12345678 -> wr high 2 cycles with mem_addr=0x200 and mem_wdata=0x12345678; rd stays 0; rdata unchanged; data_done in cycle 4.
- fetch_req and data_req rise in the same cycle, fixed priority -> data transaction completes first; fetch_gnt follows in the cycle after IDLE.
- With ARB_ROUND_ROBIN_EN, both requesters held continuously for 4 transactions -> grant order data, fetch, data, fetch (after an initial fetch if the rr pointer is at its reset value).
- Requester keeps req high for one extra cycle after done -> exactly one additional transaction is started; gnt/done pulses never overlap; rd&wr never both 1.
